// File: rtl/uart_pkg.sv
// Shared types and line levels for the word-serializing UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} tx_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;
  localparam logic IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..period-1, ticks on the last count, held at 0 by restart.
module uart_baud_tick #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == period - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (restart || tick) cnt <= '0;
    else                     cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_word_tx.sv
// Sends a captured multi-byte word as back-to-back 8N1 frames with optional idle gap per byte.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 16,
  parameter int NUM_BYTES      = 8,
  parameter int GAP_BITS       = 0,
  parameter int MSB_BYTE_FIRST = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              transmit,
  input  logic [8*NUM_BYTES-1:0]                            tx_word,
  output logic                                              tx,
  output logic                                              is_transmitting,
  output logic                                              tx_done,
  output logic [((NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1)-1:0] byte_index
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  // The counter must also hold a plain bit period when no gap is configured.
  localparam int PMAX  = ((GAP_BITS > 0) ? GAP_BITS : 1) * CLKS_PER_BIT;
  localparam int CNT_W = $clog2(PMAX + 1);

  localparam logic [CNT_W-1:0] BIT_P    = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] GAP_P    = CNT_W'(GAP_BITS * CLKS_PER_BIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [2:0]       LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  tx_state_e        state, state_n;
  logic [W-1:0]     shreg, shreg_n;
  logic [2:0]       bit_q, bit_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             tx_n, busy_n, done_n;
  logic             tick, byte_end;
  logic [7:0]       cur_byte;

  uart_baud_tick #(.CNT_W(CNT_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .period  ((state == GAP) ? GAP_P : BIT_P),
    .tick    (tick)
  );

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bit_n    = bit_q;
    idx_n    = idx_q;
    busy_n   = is_transmitting;
    done_n   = 1'b0;
    byte_end = 1'b0;
    unique case (state)
      IDLE: if (transmit) begin
        state_n = START;
        shreg_n = tx_word;
        idx_n   = '0;
        busy_n  = 1'b1;
      end
      START: if (tick) begin
        state_n = DATA;
        bit_n   = '0;
      end
      DATA: if (tick) begin
        if (bit_q == LAST_BIT) state_n = STOP;
        else                   bit_n   = bit_q + 3'd1;
      end
      STOP: if (tick) begin
        if (GAP_BITS > 0) state_n  = GAP;
        else              byte_end = 1'b1;
      end
      GAP: if (tick) byte_end = 1'b1;
      default: state_n = IDLE;
    endcase

    if (byte_end) begin
      if (idx_q == LAST_IDX) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end else begin
        state_n = START;
        idx_n   = idx_q + IDX_W'(1);
        shreg_n = (MSB_BYTE_FIRST != 0) ? (shreg << 8) : (shreg >> 8);
      end
    end

    // tx is registered from the next state so the line never glitches.
    cur_byte = (MSB_BYTE_FIRST != 0) ? shreg_n[W-1 -: 8] : shreg_n[7:0];
    case (state_n)
      IDLE:    tx_n = IDLE_LEVEL;
      START:   tx_n = START_LEVEL;
      DATA:    tx_n = cur_byte[bit_n];
      default: tx_n = STOP_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_q           <= '0;
      idx_q           <= '0;
      tx              <= IDLE_LEVEL;
      is_transmitting <= 1'b0;
      tx_done         <= 1'b0;
    end else begin
      state           <= state_n;
      shreg           <= shreg_n;
      bit_q           <= bit_n;
      idx_q           <= idx_n;
      tx              <= tx_n;
      is_transmitting <= busy_n;
      tx_done         <= done_n;
    end
  end

  assign byte_index = idx_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three configurations checked cycle by cycle against a frame-timing model.
module tb_uart_word_tx;

  localparam int NB  = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        trans [3];
  logic [63:0] word  [3];
  logic        txs   [3];
  logic        busy  [3];
  logic        done  [3];
  logic [2:0]  idx   [3];

  int gap_of [3] = '{0, 0, 1};
  int msb_of [3] = '{0, 1, 0};

  uart_word_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .GAP_BITS(0), .MSB_BYTE_FIRST(0)) u0 (
    .clk(clk), .rst(rst), .transmit(trans[0]), .tx_word(word[0]), .tx(txs[0]),
    .is_transmitting(busy[0]), .tx_done(done[0]), .byte_index(idx[0]));
  uart_word_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .GAP_BITS(0), .MSB_BYTE_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .transmit(trans[1]), .tx_word(word[1]), .tx(txs[1]),
    .is_transmitting(busy[1]), .tx_done(done[1]), .byte_index(idx[1]));
  uart_word_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .GAP_BITS(1), .MSB_BYTE_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .transmit(trans[2]), .tx_word(word[2]), .tx(txs[2]),
    .is_transmitting(busy[2]), .tx_done(done[2]), .byte_index(idx[2]));

  int   tests = 0;
  int   fails = 0;
  logic cap [0:1023];
  int   done_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int frame_len(input int k);
    return (10 + gap_of[k]) * CPB;
  endfunction

  // Line level t cycles after the first start-bit cycle, from the frame layout alone.
  function automatic logic exp_tx(input int k, input logic [63:0] w, input int t);
    int b, pos;
    logic [7:0] by;
    if (t >= NB * frame_len(k)) return 1'b1;
    b   = t / frame_len(k);
    pos = (t % frame_len(k)) / CPB;
    by  = (msb_of[k] != 0) ? w[8*(NB-1-b) +: 8] : w[8*b +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return by[pos-1];
    return 1'b1;
  endfunction

  function automatic int exp_idx(input int k, input int t);
    int b;
    b = t / frame_len(k);
    return (b > NB - 1) ? NB - 1 : b;
  endfunction

  function automatic logic [7:0] decode(input int k, input int b);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = cap[b*frame_len(k) + CPB*(1+i) + CPB/2];
    return v;
  endfunction

  task automatic start_word(input int k, input logic [63:0] w);
    trans[k] = 1'b1;
    word[k]  = w;
    @(negedge clk);
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves at a negedge.
  task automatic run_stream(input int k, input logic [63:0] w, input bit noise,
                            input bit chain, input logic [63:0] w2);
    int total, bad, first_bad, idle_bad;
    total = NB * frame_len(k);
    bad = 0; first_bad = -1; idle_bad = 0; done_t = -1;
    for (int t = 0; t <= total; t++) begin
      cap[t] = txs[k];
      if (txs[k] !== exp_tx(k, w, t) || idx[k] !== 3'(exp_idx(k, t)) ||
          busy[k] !== (t < total) || done[k] !== (t == total)) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
      if (done[k] === 1'b1 && done_t < 0) done_t = t;
      if (t == 0) begin trans[k] = 1'b0; word[k] = ~w; end
      if (noise && t == 50) begin trans[k] = 1'b1; word[k] = '1; end
      if (noise && t == 51) trans[k] = 1'b0;
      if (chain && t == total) begin trans[k] = 1'b1; word[k] = w2; end
      @(negedge clk);
    end
    check($sformatf("stream u%0d bad cycles (first at %0d)", k, first_bad), bad, 0);
    if (!chain) begin
      for (int i = 0; i < 6; i++) begin
        if (txs[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) idle_bad++;
        @(negedge clk);
      end
      check($sformatf("idle after word u%0d bad cycles", k), idle_bad, 0);
    end
  endtask

  typedef struct {
    int          k;
    logic [63:0] w;
    bit          noise;
    logic [7:0]  first;
    logic [7:0]  last;
    int          cycles;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   quiet_bad;
    logic [63:0] rw;
    int   rk;
    bit   rn;
    logic gap_ok;

    for (int k = 0; k < 3; k++) begin trans[k] = 1'b0; word[k] = '0; end

    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("async reset u%0d {tx,busy,done,idx}", k),
            {txs[k], busy[k], done[k], idx[k]}, 6'b100_000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    vecs[0] = '{0, 64'h0123456789ABCDEF, 1'b0, 8'hEF, 8'h01, 320};
    vecs[1] = '{1, 64'hA5000000000000C3, 1'b0, 8'hA5, 8'hC3, 320};
    vecs[2] = '{2, 64'h0123456789ABCDEF, 1'b0, 8'hEF, 8'h01, 352};
    vecs[3] = '{0, 64'h0,                1'b1, 8'h00, 8'h00, 320};
    vecs[4] = '{1, 64'h0123456789ABCDEF, 1'b0, 8'h01, 8'hEF, 320};

    for (int i = 0; i < 5; i++) begin
      start_word(vecs[i].k, vecs[i].w);
      run_stream(vecs[i].k, vecs[i].w, vecs[i].noise, 1'b0, '0);
      check($sformatf("vec%0d first byte", i), decode(vecs[i].k, 0), vecs[i].first);
      check($sformatf("vec%0d last byte", i), decode(vecs[i].k, NB-1), vecs[i].last);
      check($sformatf("vec%0d done cycle", i), done_t, vecs[i].cycles);
      if (vecs[i].k == 2) begin
        gap_ok = 1'b1;
        for (int t = 36; t < 44; t++) if (cap[t] !== 1'b1) gap_ok = 1'b0;
        check("gap high run then start bit", {gap_ok, cap[44]}, 2'b10);
      end
    end

    // Back-to-back: transmit held in the tx_done cycle starts the next word at once.
    start_word(0, 64'h1122334455667788);
    run_stream(0, 64'h1122334455667788, 1'b0, 1'b1, 64'h99AABBCCDDEEFF00);
    check("b2b start bit {tx,busy}", {txs[0], busy[0]}, 2'b01);
    run_stream(0, 64'h99AABBCCDDEEFF00, 1'b0, 1'b0, '0);

    // Mid-word reset during byte 3.
    start_word(0, 64'hDEADBEEFCAFEF00D);
    trans[0] = 1'b0;
    repeat (129) @(negedge clk);
    check("busy before mid-word reset", busy[0], 1'b1);
    #1 rst = 1'b0;
    #1;
    check("mid-word reset {tx,busy,done,idx}", {txs[0], busy[0], done[0], idx[0]}, 6'b100_000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txs[0] !== 1'b1 || busy[0] !== 1'b0) quiet_bad++;
    end
    check("quiet after reset release", quiet_bad, 0);
    start_word(0, 64'hDEADBEEFCAFEF00D);
    run_stream(0, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0, '0);
    check("post-reset word first byte", decode(0, 0), 8'h0D);

    for (int i = 0; i < 12; i++) begin
      rk = $urandom_range(0, 2);
      rw = {$urandom, $urandom};
      rn = 1'($urandom_range(0, 1));
      start_word(rk, rw);
      run_stream(rk, rw, rn, 1'b0, '0);
      check($sformatf("random%0d done cycle", i), done_t, NB * frame_len(rk));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
